// File: rtl/repadd_mul_ctrl.sv
// Controller for the repeated-addition multiplier: sequences load/clear/add/decrement strobes from the B==0 flag.
// Optional iteration watchdog enabled by defining MUL_TIMEOUT_EN.
module repadd_mul_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_ITER = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic eqz,
  output logic ldA,
  output logic ldB,
  output logic clrP,
  output logic ldP,
  output logic decB,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDA  = 3'd1,
    S_LDB  = 3'd2,
    S_ADD  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_timeout;
  logic   w_err;

`ifdef MUL_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  assign w_timeout = (r_cnt == CNT_W'(MAX_ITER));
  assign w_err     = r_err;

  // r_err is captured on the way into DONE so it lines up with the done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_LDB)
        r_cnt <= '0;
      else if ((r_state == S_ADD) && !eqz)
        r_cnt <= r_cnt + 1'b1;
      r_err <= (r_state == S_ADD) && !eqz && w_timeout;
    end
  end
`else
  logic w_unused_cfg;

  assign w_timeout    = 1'b0;
  assign w_err        = 1'b0;
  assign w_unused_cfg = ^{CNT_W[0], MAX_ITER[0]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // eqz is only consulted in ADD so an undriven flag elsewhere cannot leak in
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_LDA;
      S_LDA:  w_next = S_LDB;
      S_LDB:  w_next = S_ADD;
      S_ADD:  if (eqz || w_timeout) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ldA  = 1'b0;
    ldB  = 1'b0;
    clrP = 1'b0;
    ldP  = 1'b0;
    decB = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    err  = 1'b0;
    unique case (r_state)
      S_LDA: begin
        ldA  = 1'b1;
        busy = 1'b1;
      end
      S_LDB: begin
        ldB  = 1'b1;
        clrP = 1'b1;
        busy = 1'b1;
      end
      S_ADD: begin
        busy = 1'b1;
        ldP  = ~eqz;
        decB = ~eqz;
      end
      S_DONE: begin
        done = 1'b1;
        err  = w_err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_repadd_mul_ctrl.sv
// Bench for repadd_mul_ctrl with a behavioural 16-bit A/B/P datapath and a product scoreboard.
module tb_repadd_mul_ctrl;

  localparam int TB_MAX = 4;
`ifdef MUL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic eqz;
  logic ldA, ldB, clrP, ldP, decB, busy, done, err;

  logic [15:0] opA = '0, opB = '0;
  logic [15:0] bus;
  logic [15:0] dA, dB, dP;

  typedef struct {
    logic [15:0] p;
    logic        e;
  } exp_t;
  exp_t sb[$];
  exp_t ex;

  int checks = 0;
  int errors = 0;

  int g_done_cyc, g_nldp, g_nbusy, g_viol;
  int g_lda_cyc, g_ldb_cyc, g_clrp_cyc, g_first_ldp, g_last_ldp;
  logic g_err;
  logic [15:0] g_p;

  always #5 clk = ~clk;

  repadd_mul_ctrl #(.CNT_W(16), .MAX_ITER(TB_MAX)) dut (
    .clk(clk), .rst(rst), .start(start), .eqz(eqz),
    .ldA(ldA), .ldB(ldB), .clrP(clrP), .ldP(ldP), .decB(decB),
    .busy(busy), .done(done), .err(err)
  );

  assign bus = ldA ? opA : opB;
  assign eqz = (dB == 16'd0);

  always_ff @(posedge clk) begin
    if (ldA) dA <= bus;
    if (ldB) dB <= bus;
    else if (decB) dB <= dB - 16'd1;
    if (clrP) dP <= 16'd0;
    else if (ldP) dP <= dP + dA;
  end

  function automatic int n_adds(input int b);
    return (TO_EN && b > TB_MAX) ? TB_MAX + 1 : b;
  endfunction

  function automatic int exp_done_cyc(input int b);
    return (TO_EN && b > TB_MAX) ? TB_MAX + 4 : b + 4;
  endfunction

  // Launch one multiply and record strobe activity until done (cycle 1 = LDA).
  task automatic run_op(input int a, input int b, input bit retrig);
    int cyc;
    bit got;
    exp_t e;
    e.p = 16'(a * n_adds(b));
    e.e = TO_EN && (b > TB_MAX);
    sb.push_back(e);
    opA = 16'(a);
    opB = 16'(b);
    g_nldp = 0; g_nbusy = 0; g_viol = 0; g_done_cyc = -1;
    g_lda_cyc = -1; g_ldb_cyc = -1; g_clrp_cyc = -1; g_first_ldp = -1; g_last_ldp = -1;
    g_err = 1'bx; g_p = 'x;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    cyc = 1;
    got = 0;
    while (!got && cyc < 200) begin
      start = (retrig && (cyc == 2 || cyc == 4)) ? 1'b1 : 1'b0;
      if (ldA && g_lda_cyc < 0) g_lda_cyc = cyc;
      if (ldB && g_ldb_cyc < 0) g_ldb_cyc = cyc;
      if (clrP && g_clrp_cyc < 0) g_clrp_cyc = cyc;
      if (ldP) begin
        g_nldp++;
        if (g_first_ldp < 0) g_first_ldp = cyc;
        g_last_ldp = cyc;
      end
      if (busy) g_nbusy++;
      if ((ldA && ldB) || (clrP && ldP) || (ldP !== decB) || (busy && done)) g_viol++;
      if (done === 1'b1) begin
        got = 1;
        g_done_cyc = cyc;
        g_err = err;
        g_p = dP;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({ldA, ldB, clrP, ldP, decB, busy, done, err} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=00000000", {ldA, ldB, clrP, ldP, decB, busy, done, err});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ldA, ldB, clrP, ldP, decB, busy, done, err} !== 8'b0) begin
      errors++;
      $display("FAIL idle_outputs got=%b want=00000000", {ldA, ldB, clrP, ldP, decB, busy, done, err});
    end
  endtask

  task automatic test_basic();
    run_op(5, 3, 0);
    ex = sb.pop_front();
    checks++; if (g_lda_cyc !== 1) begin errors++; $display("FAIL basic_lda_cyc got=%0d want=1", g_lda_cyc); end
    checks++; if (g_ldb_cyc !== 2 || g_clrp_cyc !== 2) begin errors++; $display("FAIL basic_ldb_clrp_cyc got=%0d/%0d want=2/2", g_ldb_cyc, g_clrp_cyc); end
    checks++; if (g_first_ldp !== 3 || g_last_ldp !== 5 || g_nldp !== 3) begin errors++; $display("FAIL basic_ldp got=%0d..%0d n=%0d want=3..5 n=3", g_first_ldp, g_last_ldp, g_nldp); end
    checks++; if (g_done_cyc !== 7) begin errors++; $display("FAIL basic_done_cyc got=%0d want=7", g_done_cyc); end
    checks++; if (g_p !== ex.p || g_err !== ex.e) begin errors++; $display("FAIL basic_product got=%0d err=%b want=%0d err=%b", g_p, g_err, ex.p, ex.e); end
    checks++; if (g_nbusy !== 6) begin errors++; $display("FAIL basic_busy_cycles got=%0d want=6", g_nbusy); end
    checks++; if (g_viol !== 0) begin errors++; $display("FAIL basic_exclusivity got=%0d want=0", g_viol); end
  endtask

  task automatic test_zero_b();
    run_op(9, 0, 0);
    ex = sb.pop_front();
    checks++; if (g_nldp !== 0) begin errors++; $display("FAIL zerob_ldp got=%0d want=0", g_nldp); end
    checks++; if (g_done_cyc !== 4) begin errors++; $display("FAIL zerob_done_cyc got=%0d want=4", g_done_cyc); end
    checks++; if (g_p !== ex.p || g_err !== ex.e) begin errors++; $display("FAIL zerob_product got=%0d err=%b want=%0d err=%b", g_p, g_err, ex.p, ex.e); end
  endtask

  task automatic test_zero_a();
    run_op(0, 4, 0);
    ex = sb.pop_front();
    checks++; if (g_nldp !== 4) begin errors++; $display("FAIL zeroa_ldp got=%0d want=4", g_nldp); end
    checks++; if (g_done_cyc !== 8) begin errors++; $display("FAIL zeroa_done_cyc got=%0d want=8", g_done_cyc); end
    checks++; if (g_p !== ex.p || g_err !== ex.e) begin errors++; $display("FAIL zeroa_product got=%0d err=%b want=%0d err=%b", g_p, g_err, ex.p, ex.e); end
  endtask

  task automatic test_retrigger();
    int nb;
    run_op(5, 3, 1);
    ex = sb.pop_front();
    checks++; if (g_done_cyc !== 7 || g_nldp !== 3) begin errors++; $display("FAIL retrig_timing got=done%0d ldp%0d want=done7 ldp3", g_done_cyc, g_nldp); end
    checks++; if (g_p !== ex.p) begin errors++; $display("FAIL retrig_product got=%0d want=%0d", g_p, ex.p); end
    nb = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || ldA || done) nb++;
    end
    checks++; if (nb !== 0) begin errors++; $display("FAIL retrig_no_queue got=%0d active cycles want=0", nb); end
  endtask

  task automatic test_back_to_back();
    int cyc, nd, nl;
    int dcyc[2];
    int lcyc[2];
    exp_t e;
    e.p = 16'd14; e.e = 1'b0; sb.push_back(e);
    e.p = 16'd9;  e.e = 1'b0; sb.push_back(e);
    opA = 16'd7; opB = 16'd2;
    nd = 0; nl = 0; dcyc[0] = -1; dcyc[1] = -1; lcyc[0] = -1; lcyc[1] = -1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (nd < 2 && cyc < 100) begin
      if (ldA && nl < 2) begin lcyc[nl] = cyc; nl++; end
      if (done === 1'b1) begin
        dcyc[nd] = cyc;
        ex = sb.pop_front();
        checks++;
        if (dP !== ex.p) begin errors++; $display("FAIL b2b_product%0d got=%0d want=%0d", nd, dP, ex.p); end
        nd++;
        opA = 16'd3; opB = 16'd3;
        if (nd == 2) start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checks++; if (nd !== 2) begin errors++; $display("FAIL b2b_done_count got=%0d want=2", nd); end
    checks++; if (lcyc[0] !== 1 || dcyc[0] !== 6) begin errors++; $display("FAIL b2b_first_op got=lda%0d done%0d want=lda1 done6", lcyc[0], dcyc[0]); end
    checks++; if (lcyc[1] !== 8 || dcyc[1] !== 14) begin errors++; $display("FAIL b2b_second_op got=lda%0d done%0d want=lda8 done14", lcyc[1], dcyc[1]); end
  endtask

  task automatic test_reset_mid();
    int bad;
    opA = 16'd4; opB = 16'd10;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b1 || ldP !== 1'b1 || dP !== 16'd12) begin errors++; $display("FAIL rstmid_pre got=busy%b ldp%b P%0d want=busy1 ldp1 P12", busy, ldP, dP); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({ldA, ldB, clrP, ldP, decB, busy, done, err} !== 8'b0) begin
      errors++;
      $display("FAIL rstmid_async got=%b want=00000000", {ldA, ldB, clrP, ldP, decB, busy, done, err});
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy || done || err || ldA) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rstmid_idle got=%0d active cycles want=0", bad); end
    run_op(4, 2, 0);
    ex = sb.pop_front();
    checks++; if (g_p !== ex.p || g_done_cyc !== 6) begin errors++; $display("FAIL rstmid_after got=P%0d done%0d want=P%0d done6", g_p, g_done_cyc, ex.p); end
  endtask

`ifdef MUL_TIMEOUT_EN
  task automatic test_timeout();
    run_op(2, 10, 0);
    ex = sb.pop_front();
    checks++; if (g_nldp !== 5) begin errors++; $display("FAIL timeout_ldp got=%0d want=5", g_nldp); end
    checks++; if (g_err !== 1'b1 || g_done_cyc !== 8) begin errors++; $display("FAIL timeout_err got=err%b done%0d want=err1 done8", g_err, g_done_cyc); end
    checks++; if (g_p !== ex.p) begin errors++; $display("FAIL timeout_product got=%0d want=%0d", g_p, ex.p); end
    run_op(2, 3, 0);
    ex = sb.pop_front();
    checks++; if (g_err !== 1'b0 || g_p !== ex.p) begin errors++; $display("FAIL timeout_normal got=err%b P%0d want=err0 P%0d", g_err, g_p, ex.p); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_b();
    test_zero_a();
    test_retrigger();
    test_back_to_back();
    test_reset_mid();
`ifdef MUL_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
